apb_master_arb: RTL

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
//   Two-requester APB master. Requests are arbitrated round-robin while idle,
//   decoded onto one of two APB slaves and run through SETUP/ACCESS. Each
//   transfer ends with a one-cycle req_done pulse to its owner, qualified by
//   req_err for decode errors and PREADY timeouts.
//
// Ports
//   PCLK, PRESETn          clock, asynchronous active-low reset
//   req_valid/req_write    per-requester request and direction (bit i)
//   req_addr/req_wdata     per-requester byte at [8i+7:8i]
//   req_accept             one-hot, combinational grant in the IDLE cycle
//   req_done/req_err       one-hot completion pulse and its error flag
//   req_rdata              read data, valid while req_done is high
//   PSEL1/PSEL2/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs (registered)
//   PRDATA1/PRDATA2/PREADY                    APB slave responses
// -----------------------------------------------------------------------------
module apb_master_arb #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic [1:0]  req_accept,
    output logic [1:0]  req_done,
    output logic        req_err,
    output logic [7:0]  req_rdata,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [7:0]  PADDR,
    output logic [7:0]  PWDATA,
    input  logic [7:0]  PRDATA1,
    input  logic [7:0]  PRDATA2,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Abort fires on the ACCESS cycle whose stall brings the count to TIMEOUT.
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_psel1;
    logic        r_psel2;
    logic        r_penable;
    logic        r_pwrite;
    logic [7:0]  r_paddr;
    logic [7:0]  r_pwdata;
    logic [1:0]  r_done;
    logic        r_err;
    logic [7:0]  r_rdata;
    logic [7:0]  r_wait_cnt;

    logic        w_grant;
    logic        w_winner;
    logic [1:0]  w_win_onehot;
    logic [1:0]  w_owner_onehot;
    logic [7:0]  w_addr;
    logic [7:0]  w_wdata;
    logic        w_write;
    logic [7:0]  w_rdata_sel;

    // With both requesters valid the one not granted last wins; a lone
    // requester wins regardless of history.
    always_comb begin
        w_grant        = (r_state == ST_IDLE) && (|req_valid);
        w_winner       = (&req_valid) ? ~r_last_grant : req_valid[1];
        w_win_onehot   = w_winner ? 2'b10 : 2'b01;
        w_owner_onehot = r_owner ? 2'b10 : 2'b01;
        w_addr         = w_winner ? req_addr[15:8]  : req_addr[7:0];
        w_wdata        = w_winner ? req_wdata[15:8] : req_wdata[7:0];
        w_write        = w_winner ? req_write[1]    : req_write[0];
        w_rdata_sel    = r_psel2 ? PRDATA2 : PRDATA1;
        req_accept     = w_grant ? w_win_onehot : 2'b00;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_psel1      <= 1'b0;
            r_psel2      <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= 8'h00;
            r_pwdata     <= 8'h00;
            r_done       <= 2'b00;
            r_err        <= 1'b0;
            r_rdata      <= 8'h00;
            r_wait_cnt   <= 8'h00;
        end else begin
            // Completion outputs are single-cycle pulses.
            r_done  <= 2'b00;
            r_err   <= 1'b0;
            r_rdata <= 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        if (w_addr[6]) begin
                            // Decode error: no bus activity, report next cycle.
                            r_done <= w_win_onehot;
                            r_err  <= 1'b1;
                        end else begin
                            r_state  <= ST_SETUP;
                            r_psel1  <= ~w_addr[7];
                            r_psel2  <= w_addr[7];
                            r_paddr  <= {2'b00, w_addr[5:0]};
                            r_pwdata <= w_wdata;
                            r_pwrite <= w_write;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state    <= ST_ACCESS;
                    r_penable  <= 1'b1;
                    r_wait_cnt <= 8'h00;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        r_state   <= ST_IDLE;
                        r_psel1   <= 1'b0;
                        r_psel2   <= 1'b0;
                        r_penable <= 1'b0;
                        r_done    <= w_owner_onehot;
                        r_rdata   <= r_pwrite ? 8'h00 : w_rdata_sel;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (r_wait_cnt == LP_WAIT_LAST) begin
                            r_state   <= ST_IDLE;
                            r_psel1   <= 1'b0;
                            r_psel2   <= 1'b0;
                            r_penable <= 1'b0;
                            r_done    <= w_owner_onehot;
                            r_err     <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_done  = r_done;
    assign req_err   = r_err;
    assign req_rdata = r_rdata;
    assign PSEL1     = r_psel1;
    assign PSEL2     = r_psel2;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;

endmodule
